// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // M-extension funct3 encodings, same field the ALU decodes.
    localparam logic [2:0] FNC_MUL    = 3'b000;
    localparam logic [2:0] FNC_MULH   = 3'b001;
    localparam logic [2:0] FNC_MULHSU = 3'b010;
    localparam logic [2:0] FNC_MULHU  = 3'b011;
    localparam logic [2:0] FNC_DIV    = 3'b100;
    localparam logic [2:0] FNC_DIVU   = 3'b101;
    localparam logic [2:0] FNC_REM    = 3'b110;
    localparam logic [2:0] FNC_REMU   = 3'b111;

    // funct7 value that routes an OP instruction to this unit.
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // State encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StBusy = ST_BUSY,
        StFix  = ST_FIX,
        StDone = ST_DONE
    } muldiv_state_e;

    // rs1 is interpreted as signed.
    function automatic logic rs1_signed(input logic [2:0] funct3);
        return (funct3 == FNC_MULH) || (funct3 == FNC_MULHSU) ||
               (funct3 == FNC_DIV)  || (funct3 == FNC_REM);
    endfunction

    // rs2 is interpreted as signed.
    function automatic logic rs2_signed(input logic [2:0] funct3);
        return (funct3 == FNC_MULH) || (funct3 == FNC_DIV) || (funct3 == FNC_REM);
    endfunction

    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] funct3);
        return funct3[2] & funct3[1];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result select applied in the FIX cycle.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   rem,
    output logic [XLEN-1:0]   result
);

    logic              neg_res;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // Signs are pre-masked at accept, so unsigned ops never negate here.
    always_comb begin
        neg_res  = sign_a ^ sign_b;
        prod_fix = neg_res ? -prod : prod;
        // Quotient lives in the low half of the shared product register.
        quot_fix = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_fix  = sign_a ? -rem : rem;
        result   = prod_fix[XLEN-1:0];
        case (funct3)
            FNC_MUL:                         result = prod_fix[XLEN-1:0];
            FNC_MULH, FNC_MULHSU, FNC_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            FNC_DIV, FNC_DIVU:               result = quot_fix;
            FNC_REM, FNC_REMU:               result = rem_fix;
            default:                         result = prod_fix[XLEN-1:0];
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Multiply: shift-add, one bit per cycle. Divide: restoring, one bit per cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              sign_a;
    logic              sign_b;
    // Multiply: {acc, multiplier}. Divide: low half is dividend shifting into quotient.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   rem;

    logic              accept;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_trial;
    logic              div_ok;
    logic [XLEN-1:0]   fix_result;

    // Accept-time decode: operand magnitudes and divide special cases.
    always_comb begin
        accept      = in_valid && in_ready && !kill;
        a_neg       = rs1_signed(in_funct3) & in_a[XLEN-1];
        b_neg       = rs2_signed(in_funct3) & in_b[XLEN-1];
        a_mag       = a_neg ? -in_a : in_a;
        b_mag       = b_neg ? -in_b : in_b;
        special     = 1'b0;
        special_res = '0;
        if (is_div_op(in_funct3)) begin
            if (in_b == '0) begin
                special     = 1'b1;
                special_res = is_rem_op(in_funct3) ? in_a : '1;
            end else if (rs1_signed(in_funct3) && in_a == MOST_NEG && in_b == '1) begin
                special     = 1'b1;
                special_res = is_rem_op(in_funct3) ? '0 : in_a;
            end
        end
    end

    // One iteration step for both the multiplier and the divider.
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : '0);
        rem_shift = {rem, prod[XLEN-1]};
        div_trial = rem_shift - {1'b0, opb};
        div_ok    = !div_trial[XLEN];
    end

    muldiv_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .funct3 (op),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .prod   (prod),
        .rem    (rem),
        .result (fix_result)
    );

    // Control FSM and datapath registers; kill always wins over out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            op        <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            prod      <= '0;
            opb       <= '0;
            rem       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        op       <= in_funct3;
                        sign_a   <= a_neg;
                        sign_b   <= b_neg;
                        prod     <= {{XLEN{1'b0}}, a_mag};
                        opb      <= b_mag;
                        rem      <= '0;
                        cnt      <= CNT_W'(XLEN);
                        in_ready <= 1'b0;
                        if (special) begin
                            out_data  <= special_res;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else begin
                            state <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (kill) begin
                        state    <= StIdle;
                        in_ready <= 1'b1;
                    end else begin
                        if (is_div_op(op)) begin
                            rem              <= div_ok ? div_trial[XLEN-1:0] : rem_shift[XLEN-1:0];
                            prod[XLEN-1:0]   <= {prod[XLEN-2:0], div_ok};
                        end else begin
                            prod <= {mul_sum, prod[XLEN-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (kill) begin
                        state    <= StIdle;
                        in_ready <= 1'b1;
                    end else begin
                        out_data  <= fix_result;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (kill || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct3 (in_funct3),
        .in_a      (in_a),
        .in_b      (in_b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0] ua, ub, p;
        logic signed [31:0] a32, b32, q32;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sub = ub;
        a32 = a;
        b32 = b;
        p   = '0;
        r   = '0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * sub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin q32 = a32 / b32; r = q32; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else begin q32 = a32 % b32; r = q32; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 15);
            6: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    // Present one request; returns once the accept edge has passed.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = f;
        in_a      = a;
        in_b      = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        // Scramble inputs after accept; the unit must ignore them.
        in_funct3 = 3'($urandom);
        in_a      = $urandom;
        in_b      = $urandom;
    endtask

    // Run an op; lat counts edges from the accept edge to out_valid, -1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        out_ready = 1'b0;
        start_op(f, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out_data;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h, want 1 0 0",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  fs   [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                   3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as   [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                   -32'd7, -32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                   32'd2, 32'd2, 32'd16, 32'd16,
                                   32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] want [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h0000_000F,
                                   32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int          wlat [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_op(fs[i], as[i], bs[i], res, lat);
            checks++;
            if (res !== want[i]) begin
                errors++;
                $display("FAIL directed[%0d] data: got %h, want %h", i, res, want[i]);
            end
            checks++;
            if (lat != wlat[i]) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, wlat[i]);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op(f, a, b, res, lat);
            checks++;
            if (res !== ref_result(f, a, b)) begin
                errors++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: got %h, want %h",
                         i, f, a, b, res, ref_result(f, a, b));
            end
            checks++;
            if (lat != ref_latency(f, a, b)) begin
                errors++;
                $display("FAIL random[%0d] latency: got %0d, want %0d",
                         i, lat, ref_latency(f, a, b));
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int          lat;
        int          bad;
        run_op(3'd0, 32'd1234, 32'd5678, res, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== 32'd7006652 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure hold: %0d bad cycles, last out_data=%h want %h",
                     bad, out_data, 32'd7006652);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure release: out_valid=%b in_ready=%b, want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_kill();
        int          seen;
        logic [31:0] res;
        int          lat;
        // Kill in IDLE blocks the accept.
        @(negedge clk);
        kill      = 1'b1;
        in_valid  = 1'b1;
        in_funct3 = 3'd0;
        in_a      = 32'd2;
        in_b      = 32'd2;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_idle: in_ready=%b, want 1", in_ready);
        end
        // Kill at BUSY cycle 5.
        start_op(3'd0, 32'd9, 32'd9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        // Async reset mid-BUSY, asserted between edges.
        start_op(3'd4, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b out_data=%h, want 1 0 0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL kill_no_output: out_valid seen %0d cycles, want 0", seen);
        end
        // Kill in DONE drops the result even with out_ready low.
        run_op(3'd5, 32'd10, 32'd0, res, lat);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_done: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        // Fresh op afterwards.
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        checks++;
        if (res !== 32'd12 || lat != 34) begin
            errors++;
            $display("FAIL after_kill: got %h lat %0d, want %h lat 34", res, lat, 32'd12);
        end
        release_out();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_funct3 = 3'd0;
        in_a      = '0;
        in_b      = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_kill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit; successor to the single-cycle integer ALU.
- Sits beside the ALU in the execute stage and takes the same funct3 encoding for the eight M-extension ops.
- Parametrised in operand width.
- Multi-cycle, with valid/ready handshakes on input and output so the pipeline stalls while it is busy.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 4 and even.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept (high only in IDLE).
- in_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- kill  in  1  pipeline flush; aborts any op in flight.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  XLEN  result.

Behaviour:
- Reset (async, active-high) state and outputs:
  - State = IDLE.
  - in_ready = 1, out_valid = 0, out_data = 0.
  - Counter and internal registers = 0.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - Accept occurs when in_valid && in_ready && !kill.
  - On accept, latch funct3 and the operand signs. Take absolute values of operands that are treated as signed: MULH both, MULHSU rs1 only, DIV/REM both.
  - On accept, load counter = XLEN.
  - Next state is BUSY, except for the divide special cases below, which go to DONE.
- Divide special cases, detected at accept; result registered, latency 1 cycle:
  - b == 0: DIV/DIVU -> all ones. REM/REMU -> in_a.
  - Signed overflow, DIV/REM with a == most-negative and b == all ones: DIV -> in_a, REM -> 0.
- BUSY, multiply ops: shift-add, one bit per cycle, into a 2*XLEN product register.
- BUSY, divide ops: restoring division, one quotient bit per cycle. Partial remainder is XLEN+1 bits.
- BUSY: counter decrements each cycle. At counter == 1, next state is FIX.
- FIX: one cycle. Applies result negation where needed and selects the output, then goes to DONE.
  - Product is negated if the operand signs differ (MULHSU: rs1 sign only).
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - MUL returns product[XLEN-1:0]. MULH* return product[2XLEN-1:XLEN].
- DONE:
  - out_valid = 1 and out_data is held stable while out_ready = 0.
  - When out_ready = 1: next state IDLE, out_valid drops the next cycle.
  - Back-to-back accept in the same cycle as the DONE handshake is not permitted; in_ready is high only in IDLE.
- Latency:
  - Normal op: XLEN+2 cycles from the accept edge to out_valid. For XLEN=32 that is 34 (32 BUSY + FIX + DONE entry).
  - Special case: 1 cycle.
- kill:
  - In BUSY, FIX or DONE: next state IDLE, out_valid = 0 next cycle, result discarded.
  - In IDLE: blocks accept.
  - kill has priority over out_ready.
- Reset mid-operation: immediate return to reset state; no output is produced.
- Changes on in_a/in_b/in_funct3 after accept have no effect.
- Arithmetic:
  - All internal arithmetic is unsigned on the magnitudes.
  - Sign handling occurs only at accept and in FIX.
  - The magnitude of the most-negative value is representable in XLEN unsigned bits.

Decomposition:
- Shared package/header, alongside the existing opcode header:
  - M-extension funct3 constants (FNC_MUL … FNC_REMU).
  - funct7 constant 0000001 identifying M ops.
  - State encoding localparams.
- One natural sub-module: muldiv_sign_fix, the combinational conditional-negate and result-select used in FIX. Everything else stays in muldiv_unit.

Test Plan:
- MUL, a=7, b=-3 (0xFFFFFFFD) -> out_data 0xFFFFFFEB; out_valid exactly 34 cycles after accept.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM a=-7, b=2 -> 0xFFFFFFFF. DIVU a=0xFFFFFFFF, b=16 -> 0x0FFFFFFF. REMU same operands -> 0x0000000F.
- Special cases, each with out_valid 1 cycle after accept:
  - DIV x/0 with a=5 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / -1 -> 0x80000000.
  - REM 0x80000000 / -1 -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- kill asserted at BUSY cycle 5, then separately rst asserted mid-BUSY (async, off-edge) -> no out_valid is ever produced, and a fresh MUL 3*4 afterwards returns 12.
